od_line_bridge: RTL

Parametrised, multi-line, bidirectional open-drain bridge between an A-side bus and a B-side bus, for I2C-style passthrough between a host header and on-board peripherals. Each line has its own input synchroniser, glitch filter, direction-locking state machine, per-line release holdoff, and stuck-low timeout. The block is pad-agnostic: it consumes pad inputs and produces output-enables for top-level SB_IO instances wired as D_OUT_0 = 0, so an asserted OE drives the pin low.

---
 rtl/od_line_bridge.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/od_line_bridge.sv
// od_line_bridge: multi-line bidirectional open-drain bridge between an A-side
// and a B-side bus. Each line synchronises and filters both pad inputs, then a
// small FSM locks the direction of whichever side pulled low first and drives
// the opposite side's output-enable. An asserted OE pulls the pad low.
module od_line_bridge #(
  parameter int                       NUM_LINES      = 2,
  parameter int                       SYNC_STAGES    = 2,
  parameter int                       FILTER_LEN     = 2,
  parameter logic [8*NUM_LINES-1:0]   HOLDOFF        = {8'd7, 8'd15},
  parameter int                       TIMEOUT_W      = 16,
  parameter logic [TIMEOUT_W-1:0]     TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic                 ICE_CLK,
  input  logic                 RST_N,
  input  logic                 ENABLE,
  input  logic [NUM_LINES-1:0] A_DI,
  input  logic [NUM_LINES-1:0] B_DI,
  output logic [NUM_LINES-1:0] A_OE,
  output logic [NUM_LINES-1:0] B_OE,
  output logic [NUM_LINES-1:0] BUSY,
  output logic [NUM_LINES-1:0] STUCK,
  input  logic                 STUCK_CLR
);

  // Filter counter only needs to reach FILTER_LEN-1.
  localparam int                   FCW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0]       FLAST = FCW'(FILTER_LEN - 1);
  // A timeout value of zero switches the stuck-low detector off.
  localparam bit                   TO_EN = (TIMEOUT_CYCLES != '0);
  localparam logic [TIMEOUT_W-1:0] TLAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A2B,
    ST_B2A,
    ST_HOLD,
    ST_STUCK
  } state_t;

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    logic [1:0] pad;   // bit 0 = A side, bit 1 = B side
    logic [1:0] filt;  // filtered levels, same ordering
    logic       fa;
    logic       fb;

    assign pad = {B_DI[gi], A_DI[gi]};

    for (genvar gs = 0; gs < 2; gs++) begin : g_side
      logic [SYNC_STAGES-1:0] sync;
      logic [FCW-1:0]         cnt;
      logic                   lvl;

      // Synchronise the pad, then accept a new level only after it has been
      // stable for FILTER_LEN cycles; bus idles high, so reset to 1.
      always_ff @(posedge ICE_CLK or negedge RST_N) begin
        if (!RST_N) begin
          sync <= '1;
          lvl  <= 1'b1;
          cnt  <= '0;
        end else begin
          sync <= {sync[SYNC_STAGES-2:0], pad[gs]};
          if (sync[SYNC_STAGES-1] == lvl) begin
            cnt <= '0;
          end else if (cnt == FLAST) begin
            lvl <= sync[SYNC_STAGES-1];
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign filt[gs] = lvl;
    end

    assign fa = filt[0];
    assign fb = filt[1];

    state_t                 state_reg, state_next;
    logic [7:0]             hold_reg, hold_next;
    logic [TIMEOUT_W-1:0]   timer_reg, timer_next;
    logic                   stuck_reg, stuck_next;
    logic                   set_stuck;

    // State, holdoff counter, timeout timer and sticky flag registers.
    always_ff @(posedge ICE_CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_reg <= ST_IDLE;
        hold_reg  <= '0;
        timer_reg <= '0;
        stuck_reg <= 1'b0;
      end else begin
        state_reg <= state_next;
        hold_reg  <= hold_next;
        timer_reg <= timer_next;
        stuck_reg <= stuck_next;
      end
    end

    // Direction lock: the first side seen low (A on a tie) owns the line; the
    // driven side is ignored because its low is our own drive.
    always_comb begin
      state_next = state_reg;
      hold_next  = hold_reg;
      timer_next = timer_reg;
      set_stuck  = 1'b0;
      if (!ENABLE) begin
        state_next = ST_IDLE;
        hold_next  = '0;
        timer_next = '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (!fa) begin
              state_next = ST_A2B;
              timer_next = '0;
            end else if (!fb) begin
              state_next = ST_B2A;
              timer_next = '0;
            end
          end
          ST_A2B: begin
            if (fa) begin
              state_next = ST_HOLD;
              hold_next  = HOLDOFF[8*gi +: 8];
            end else if (TO_EN && (timer_reg == TLAST)) begin
              state_next = ST_STUCK;
              set_stuck  = 1'b1;
            end else if (timer_reg != '1) begin
              timer_next = timer_reg + 1'b1;
            end
          end
          ST_B2A: begin
            if (fb) begin
              state_next = ST_HOLD;
              hold_next  = HOLDOFF[8*gi +: 8];
            end else if (TO_EN && (timer_reg == TLAST)) begin
              state_next = ST_STUCK;
              set_stuck  = 1'b1;
            end else if (timer_reg != '1) begin
              timer_next = timer_reg + 1'b1;
            end
          end
          ST_HOLD: begin
            // Ignore both sides while the released side rises back up.
            if (hold_reg == '0) begin
              state_next = ST_IDLE;
            end else begin
              hold_next = hold_reg - 1'b1;
            end
          end
          ST_STUCK: begin
            if (fa && fb) begin
              state_next = ST_IDLE;
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end
      // A coincident timeout beats the clear request.
      stuck_next = set_stuck ? 1'b1 : (STUCK_CLR ? 1'b0 : stuck_reg);
    end

    assign B_OE[gi]  = (state_reg == ST_A2B);
    assign A_OE[gi]  = (state_reg == ST_B2A);
    assign BUSY[gi]  = (state_reg == ST_A2B) || (state_reg == ST_B2A) || (state_reg == ST_HOLD);
    assign STUCK[gi] = stuck_reg;
  end

endmodule
